// File: rtl/jtag_tap_ctrl_pkg.sv
// Shared JTAG definitions: instruction opcodes, IR capture pattern and
// the 1149.1 TAP state encoding.
package jtag_tap_ctrl_pkg;

  localparam int unsigned IR_LEN = 4;

  typedef logic [IR_LEN-1:0] inst_t;

  localparam inst_t IDCODE_INST   = 4'h2;
  localparam inst_t CSR_ADDR_INST = 4'h3;
  localparam inst_t CSR_DATA_INST = 4'h4;
  localparam inst_t BYPASS_INST   = 4'hF;

  localparam inst_t       IR_CAPTURE  = inst_t'(2'b01);
  localparam logic [31:0] IDCODE_DATA = 32'h1BA0_54CB;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'hF,
    RUN_TEST_IDLE    = 4'hC,
    SELECT_DR        = 4'h7,
    CAPTURE_DR       = 4'h6,
    SHIFT_DR         = 4'h2,
    EXIT1_DR         = 4'h1,
    PAUSE_DR         = 4'h3,
    EXIT2_DR         = 4'h0,
    UPDATE_DR        = 4'h5,
    SELECT_IR        = 4'h4,
    CAPTURE_IR       = 4'hE,
    SHIFT_IR         = 4'hA,
    EXIT1_IR         = 4'h9,
    PAUSE_IR         = 4'hB,
    EXIT2_IR         = 4'h8,
    UPDATE_IR        = 4'hD
  } tap_state_t;

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Signal bundle between the TAP controller and the pad / data-register side.
interface jtag_tap_ctrl_if;
  import jtag_tap_ctrl_pkg::*;

  logic  tms;
  logic  tdi;
  logic  dr_tdo;
  logic  tdo;
  logic  tdo_en;
  logic  capdr;
  logic  shiftdr;
  logic  updatedr;
  inst_t curr_inst;
  logic  tlr;
  logic  runidle;

  modport master (
    input  tms, tdi, dr_tdo,
    output tdo, tdo_en, capdr, shiftdr, updatedr, curr_inst, tlr, runidle
  );

  modport slave (
    output tms, tdi, dr_tdo,
    input  tdo, tdo_en, capdr, shiftdr, updatedr, curr_inst, tlr, runidle
  );
endinterface

// File: rtl/jtag_tap_ctrl_fsm.sv
// 16-state 1149.1 TAP state machine with combinational state decodes.
module jtag_tap_ctrl_fsm
  import jtag_tap_ctrl_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output logic       capdr,
  output logic       shiftdr,
  output logic       updatedr,
  output logic       tlr,
  output logic       runidle
);

  tap_state_t state_nxt;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= TEST_LOGIC_RESET;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = TEST_LOGIC_RESET;
    case (state)
      TEST_LOGIC_RESET: state_nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_nxt = tms ? SELECT_DR  : RUN_TEST_IDLE;
      SELECT_DR:        state_nxt = tms ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR:       state_nxt = tms ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:         state_nxt = tms ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:         state_nxt = tms ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:         state_nxt = tms ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:         state_nxt = tms ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:        state_nxt = tms ? SELECT_DR  : RUN_TEST_IDLE;
      SELECT_IR:        state_nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_nxt = tms ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:         state_nxt = tms ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:         state_nxt = tms ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:         state_nxt = tms ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:         state_nxt = tms ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:        state_nxt = tms ? SELECT_DR  : RUN_TEST_IDLE;
      default:          state_nxt = TEST_LOGIC_RESET;
    endcase
  end

  assign capdr    = (state == CAPTURE_DR);
  assign shiftdr  = (state == SHIFT_DR);
  assign updatedr = (state == UPDATE_DR);
  assign tlr      = (state == TEST_LOGIC_RESET);
  assign runidle  = (state == RUN_TEST_IDLE);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: FSM, instruction register and negedge-registered tdo mux.
module jtag_tap_ctrl #(
  parameter jtag_tap_ctrl_pkg::inst_t IR_CAPTURE    = jtag_tap_ctrl_pkg::IR_CAPTURE,
  parameter jtag_tap_ctrl_pkg::inst_t IR_RESET_INST = jtag_tap_ctrl_pkg::IDCODE_INST
) (
  input logic             tck,
  input logic             trst,
  jtag_tap_ctrl_if.master bus
);
  import jtag_tap_ctrl_pkg::*;

  tap_state_t state;
  inst_t      ir_shift;
  inst_t      curr_inst;
  logic       sel_ir;
  logic       ir_tdo;
  logic       tdo_en;

  jtag_tap_ctrl_fsm u_fsm (
    .tck      (tck),
    .trst     (trst),
    .tms      (bus.tms),
    .state    (state),
    .capdr    (bus.capdr),
    .shiftdr  (bus.shiftdr),
    .updatedr (bus.updatedr),
    .tlr      (bus.tlr),
    .runidle  (bus.runidle)
  );

  always_ff @(posedge tck or posedge trst) begin
    if (trst)                     ir_shift <= IR_CAPTURE;
    else if (state == CAPTURE_IR) ir_shift <= IR_CAPTURE;
    else if (state == SHIFT_IR)   ir_shift <= {bus.tdi, ir_shift[IR_LEN-1:1]};
  end

  // Falling-edge stage: instruction update and tdo sources change half a
  // cycle after the state, so the far end samples stable data on posedge.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      curr_inst <= IR_RESET_INST;
      sel_ir    <= 1'b0;
      ir_tdo    <= 1'b0;
      tdo_en    <= 1'b0;
    end else begin
      if (state == UPDATE_IR)             curr_inst <= ir_shift;
      else if (state == TEST_LOGIC_RESET) curr_inst <= IR_RESET_INST;
      sel_ir <= (state == SHIFT_IR);
      ir_tdo <= ir_shift[0];
      tdo_en <= (state == SHIFT_IR) || (state == SHIFT_DR);
    end
  end

  assign bus.curr_inst = curr_inst;
  assign bus.tdo_en    = tdo_en;
  assign bus.tdo       = tdo_en ? (sel_ir ? ir_tdo : bus.dr_tdo) : 1'b0;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized scoreboard bench for jtag_tap_ctrl with a small data-register
// stand-in providing dr_tdo.
module tb_jtag_tap_ctrl;
  import jtag_tap_ctrl_pkg::*;

  typedef struct {
    bit    upd;
    inst_t inst;
  } evt_t;

  logic tck  = 1'b0;
  logic trst = 1'b0;
  bit   clk_run = 1'b0;

  int checks   = 0;
  int failures = 0;

  bit    exp_tdo[$];
  evt_t  exp_evt[$];
  bit    mq[$];
  inst_t model_inst;

  jtag_tap_ctrl_if jif ();

  jtag_tap_ctrl #(
    .IR_CAPTURE    (IR_CAPTURE),
    .IR_RESET_INST (IDCODE_INST)
  ) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (jif.master)
  );

  initial begin
    wait (clk_run);
    forever #5 tck = ~tck;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned dr_len(inst_t i);
    case (i)
      IDCODE_INST:   return 32;
      CSR_ADDR_INST: return 8;
      CSR_DATA_INST: return 16;
      default:       return 1;
    endcase
  endfunction

  function automatic logic [31:0] dr_cap(inst_t i);
    case (i)
      IDCODE_INST:   return IDCODE_DATA;
      CSR_ADDR_INST: return 32'h0000_00A5;
      CSR_DATA_INST: return 32'h0000_3C96;
      default:       return 32'h0;
    endcase
  endfunction

  // Data-register stand-in: captures, shifts within the selected length.
  logic [31:0] dr_sr;
  always @(posedge tck or posedge trst) begin
    if (trst) dr_sr <= '0;
    else if (jif.capdr) dr_sr <= dr_cap(jif.curr_inst);
    else if (jif.shiftdr)
      dr_sr <= (dr_sr >> 1) | ({31'b0, jif.tdi} << (dr_len(jif.curr_inst) - 1));
  end
  always @(negedge tck or posedge trst) begin
    if (trst) jif.dr_tdo <= 1'b0;
    else      jif.dr_tdo <= dr_sr[0];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents serial data or a
  // capture/update strobe.
  initial begin
    evt_t e;
    bit   b;
    forever begin
      @(negedge tck);
      #2;
      if (jif.tdo_en) begin
        if (exp_tdo.size() == 0) check("tdo_en_unexpected", jif.tdo_en, 0);
        else begin
          b = exp_tdo.pop_front();
          check("tdo_bit", jif.tdo, b);
        end
      end else begin
        check("tdo_idle", jif.tdo, 0);
      end
      if (jif.capdr || jif.updatedr) begin
        if (exp_evt.size() == 0)
          check("strobe_unexpected", {jif.capdr, jif.updatedr}, 0);
        else begin
          e = exp_evt.pop_front();
          check("strobe_updatedr", jif.updatedr, e.upd);
          check("strobe_capdr", jif.capdr, !e.upd);
          check("strobe_inst", jif.curr_inst, e.inst);
        end
      end
    end
  end

  task automatic step(bit t, bit d = 1'b0);
    @(negedge tck);
    #1;
    jif.tms = t;
    jif.tdi = d;
    @(posedge tck);
  endtask

  task automatic push_evt(bit upd, inst_t inst);
    evt_t e;
    e.upd  = upd;
    e.inst = inst;
    exp_evt.push_back(e);
  endtask

  function automatic void load_mq(logic [31:0] v, int unsigned len);
    mq.delete();
    for (int unsigned i = 0; i < len; i++) mq.push_back(v[i]);
  endfunction

  // Shift n bits from a Shift state, optionally pausing after pause_at bits;
  // ends in Exit1.
  task automatic shift_bits(int unsigned n, logic [63:0] data,
                            int unsigned pause_at, int unsigned pause_len);
    bit last;
    for (int unsigned i = 0; i < n; i++) begin
      exp_tdo.push_back(mq.pop_front());
      mq.push_back(data[i]);
      last = (i == n - 1) || (i + 1 == pause_at);
      step(last, data[i]);
      if (i + 1 == pause_at && i != n - 1) begin
        step(0);
        repeat (pause_len) step(0);
        step(1);
        step(0);
      end
    end
  endtask

  task automatic dr_scan(int unsigned n, int unsigned pause_at, int unsigned pause_len);
    logic [63:0] data;
    data = {$urandom, $urandom};
    load_mq(dr_cap(model_inst), dr_len(model_inst));
    step(1);
    step(0);
    push_evt(0, model_inst);
    step(n == 0);
    shift_bits(n, data, pause_at, pause_len);
    step(1);
    push_evt(1, model_inst);
    step(0);
    #2;
    check("dr_scan_runidle", jif.runidle, 1);
  endtask

  task automatic ir_scan(int unsigned n, logic [63:0] data,
                         int unsigned pause_at, int unsigned pause_len);
    load_mq(IR_CAPTURE, IR_LEN);
    step(1);
    step(1);
    step(0);
    step(n == 0);
    shift_bits(n, data, pause_at, pause_len);
    step(1);
    step(0);
    for (int unsigned i = 0; i < IR_LEN; i++) model_inst[i] = mq[i];
    #2;
    check("ir_scan_curr_inst", jif.curr_inst, model_inst);
    check("ir_scan_runidle", jif.runidle, 1);
  endtask

  // Five tms=1 cycles starting in Shift-DR after k-1 plain shifts.
  task automatic tms_reset_from_dr(int unsigned k);
    bit d;
    load_mq(dr_cap(model_inst), dr_len(model_inst));
    step(1);
    step(0);
    push_evt(0, model_inst);
    step(0);
    for (int unsigned i = 0; i < k; i++) begin
      d = 1'($urandom);
      exp_tdo.push_back(mq.pop_front());
      mq.push_back(d);
      step(i == k - 1, d);
    end
    step(1);
    push_evt(1, model_inst);
    step(1);
    step(1);
    step(1);
    #2;
    check("tms_reset_tlr", jif.tlr, 1);
    @(negedge tck);
    #2;
    model_inst = IDCODE_INST;
    check("tms_reset_curr_inst", jif.curr_inst, model_inst);
    step(0);
  endtask

  task automatic trst_mid_ir(int unsigned k);
    bit d;
    load_mq(IR_CAPTURE, IR_LEN);
    step(1);
    step(1);
    step(0);
    step(0);
    for (int unsigned i = 0; i < k; i++) begin
      d = 1'($urandom);
      exp_tdo.push_back(mq.pop_front());
      mq.push_back(d);
      step(0, d);
    end
    #2;
    trst = 1'b1;
    #1;
    model_inst = IDCODE_INST;
    check("trst_tlr", jif.tlr, 1);
    check("trst_curr_inst", jif.curr_inst, model_inst);
    check("trst_tdo_en", jif.tdo_en, 0);
    check("trst_tdo", jif.tdo, 0);
    trst = 1'b0;
    step(0);
  endtask

  initial begin
    inst_t ops[4];
    int unsigned op, n, pa;
    ops[0] = IDCODE_INST;
    ops[1] = CSR_ADDR_INST;
    ops[2] = CSR_DATA_INST;
    ops[3] = BYPASS_INST;
    jif.tms = 1'b1;
    jif.tdi = 1'b0;

    // Reset with the clock stopped.
    #1 trst = 1'b1;
    #2 trst = 1'b0;
    #1;
    model_inst = IDCODE_INST;
    check("reset_tlr", jif.tlr, 1);
    check("reset_curr_inst", jif.curr_inst, model_inst);
    check("reset_tdo_en", jif.tdo_en, 0);
    check("reset_tdo", jif.tdo, 0);
    check("reset_strobes", {jif.capdr, jif.shiftdr, jif.updatedr, jif.runidle}, 0);
    clk_run = 1'b1;

    step(1);
    #2 check("tlr_hold", jif.tlr, 1);
    step(0);
    #2 check("enter_runidle", jif.runidle, 1);

    dr_scan(32, 0, 0);
    ir_scan(IR_LEN, 64'(CSR_DATA_INST), 0, 0);
    dr_scan(16, 0, 0);
    ir_scan(IR_LEN, 64'(IDCODE_INST), 0, 0);
    dr_scan(32, 16, 5);
    ir_scan(IR_LEN, 64'(CSR_ADDR_INST), 0, 0);
    tms_reset_from_dr(3);
    trst_mid_ir(3);
    ir_scan(0, 64'h0, 0, 0);
    dr_scan(0, 0, 0);
    dr_scan(4, 0, 0);
    ir_scan(IR_LEN, 64'(IDCODE_INST), 2, 3);

    repeat (60) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          n  = $urandom_range(0, 40);
          pa = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
          dr_scan(n, pa, $urandom_range(0, 4));
        end
        2: begin
          if ($urandom_range(0, 2) != 0)
            ir_scan(IR_LEN, 64'(ops[$urandom_range(0, 3)]), 0, 0);
          else begin
            n  = $urandom_range(0, 10);
            pa = (n > 1) ? $urandom_range(0, n - 1) : 0;
            ir_scan(n, {$urandom, $urandom}, pa, $urandom_range(0, 3));
          end
        end
        3: tms_reset_from_dr($urandom_range(1, 10));
        4: trst_mid_ir($urandom_range(1, 6));
        default: begin
          repeat ($urandom_range(1, 4)) step(0);
          #2 check("idle_runidle", jif.runidle, 1);
        end
      endcase
    end

    repeat (3) step(0);
    #2;
    check("tdo_queue_drained", exp_tdo.size(), 0);
    check("strobe_queue_drained", exp_evt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
